// File: rtl/commit_ctrl.sv
// commit_ctrl: retirement sequencer at the ROB head.
// ALU ops retire in the cycle they are seen at the head.
// Loads and stores first go through a req/ack handshake with the LSU.
module commit_ctrl #(
    parameter int ARCH_REG_WIDTH = 5,
    parameter int PHYS_REG_WIDTH = 6,
    parameter int INSTRET_WIDTH  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rob_empty,
    input  logic                      head_ready,
    input  logic                      head_store,
    input  logic                      head_load,
    input  logic                      head_regwrite,
    input  logic [ARCH_REG_WIDTH-1:0] head_rd,
    input  logic [PHYS_REG_WIDTH-1:0] head_pd,
    input  logic [PHYS_REG_WIDTH-1:0] head_old_pd,
    input  logic                      commit_hold,
    output logic                      store_req,
    input  logic                      store_ack,
    output logic                      load_req,
    input  logic                      load_ack,
    output logic                      rob_ren,
    output logic                      rrf_wen,
    output logic [ARCH_REG_WIDTH-1:0] rrf_rd,
    output logic [PHYS_REG_WIDTH-1:0] rrf_pd,
    output logic                      free_push,
    output logic [PHYS_REG_WIDTH-1:0] free_pd,
    output logic [INSTRET_WIDTH-1:0]  instret,
    output logic                      busy
);

    typedef enum logic [1:0] {RUN, ST_WAIT, LD_WAIT} state_t;

    state_t state, state_nxt;
    logic   hv;
    logic   retire;
    logic   wb;

    // A head entry only counts when the ROB is non-empty; rob_empty wins.
    assign hv = ~rob_empty & head_ready;

    // State register, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) state <= RUN;
        else      state <= state_nxt;
    end

    // Retired-instruction counter, wraps naturally at full width.
    always_ff @(posedge clk) begin
        if (!rst)        instret <= '0;
        else if (retire) instret <= instret + INSTRET_WIDTH'(1);
    end

    // Next-state and retire decision; nothing retires while reset is held.
    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        if (rst) begin
            case (state)
                RUN: begin
                    if (hv && !commit_hold) begin
                        if (head_store)     state_nxt = ST_WAIT;
                        else if (head_load) state_nxt = LD_WAIT;
                        else                retire    = 1'b1;
                    end
                end
                ST_WAIT: begin
                    // commit_hold is deliberately ignored once a launch is in flight.
                    if (store_ack) begin
                        retire    = 1'b1;
                        state_nxt = RUN;
                    end
                end
                LD_WAIT: begin
                    if (load_ack) begin
                        retire    = 1'b1;
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // Writeback/free only for real destinations; x0 is never renamed.
    always_comb begin
        wb        = retire & head_regwrite & (head_rd != '0);
        rob_ren   = retire;
        rrf_wen   = wb;
        rrf_rd    = wb ? head_rd : '0;
        rrf_pd    = wb ? head_pd : '0;
        free_push = wb;
        free_pd   = wb ? head_old_pd : '0;
    end

    // Requests are pure decodes of the state register, so there is no
    // combinational path from ack back to req.
    assign store_req = (state == ST_WAIT);
    assign load_req  = (state == LD_WAIT);
    assign busy      = (state != RUN);

endmodule

// File: tb/tb_commit_ctrl.sv
// Self-checking bench for commit_ctrl: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_commit_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rob_empty, head_ready, head_store, head_load, head_regwrite;
    logic [4:0]  head_rd;
    logic [5:0]  head_pd, head_old_pd;
    logic        commit_hold, store_ack, load_ack;
    logic        store_req, load_req, rob_ren, rrf_wen, free_push, busy;
    logic [4:0]  rrf_rd;
    logic [5:0]  rrf_pd, free_pd;
    logic [63:0] instret;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    commit_ctrl #(.ARCH_REG_WIDTH(5), .PHYS_REG_WIDTH(6), .INSTRET_WIDTH(64)) dut (
        .clk(clk), .rst(rst), .rob_empty(rob_empty), .head_ready(head_ready),
        .head_store(head_store), .head_load(head_load), .head_regwrite(head_regwrite),
        .head_rd(head_rd), .head_pd(head_pd), .head_old_pd(head_old_pd),
        .commit_hold(commit_hold), .store_req(store_req), .store_ack(store_ack),
        .load_req(load_req), .load_ack(load_ack), .rob_ren(rob_ren), .rrf_wen(rrf_wen),
        .rrf_rd(rrf_rd), .rrf_pd(rrf_pd), .free_push(free_push), .free_pd(free_pd),
        .instret(instret), .busy(busy)
    );

    // Advance to 1ns after the next rising edge (drive point).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Settle combinational outputs before sampling (still far from the edge).
    task automatic settle();
        #2;
    endtask

    task automatic set_head(input logic e, input logic r, input logic st, input logic ld,
                            input logic rw, input logic [4:0] rd, input logic [5:0] pd,
                            input logic [5:0] opd);
        rob_empty = e; head_ready = r; head_store = st; head_load = ld;
        head_regwrite = rw; head_rd = rd; head_pd = pd; head_old_pd = opd;
    endtask

    task automatic idle();
        set_head(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 6'd0);
        commit_hold = 1'b0; store_ack = 1'b0; load_ack = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        // An otherwise retirable ALU op must not retire while reset is held.
        set_head(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 6'd8, 6'd2);
        cyc();
        settle();
        tests++;
        if (rob_ren !== 1'b0) begin fails++; $display("FAIL reset_rob_ren: got %0b expected 0", rob_ren); end
        tests++;
        if (instret !== 64'd0) begin fails++; $display("FAIL reset_instret: got %0d expected 0", instret); end
        tests++;
        if ({store_req, load_req, busy, rrf_wen, free_push} !== 5'b0) begin
            fails++; $display("FAIL reset_outputs: got %b expected 00000", {store_req, load_req, busy, rrf_wen, free_push});
        end
        idle();
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_alu();
        set_head(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 6'd12, 6'd3);
        settle();
        tests++;
        if ({rob_ren, rrf_wen, free_push} !== 3'b111) begin
            fails++; $display("FAIL alu_strobes: got %b expected 111", {rob_ren, rrf_wen, free_push});
        end
        tests++;
        if (rrf_rd !== 5'd5 || rrf_pd !== 6'd12 || free_pd !== 6'd3) begin
            fails++; $display("FAIL alu_fields: got rd=%0d pd=%0d free=%0d expected 5 12 3", rrf_rd, rrf_pd, free_pd);
        end
        cyc();
        idle();
        tests++;
        if (instret !== 64'd1) begin fails++; $display("FAIL alu_instret: got %0d expected 1", instret); end
    endtask

    task automatic test_rd0();
        set_head(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 6'd30, 6'd31);
        settle();
        tests++;
        if ({rob_ren, rrf_wen, free_push} !== 3'b100) begin
            fails++; $display("FAIL rd0_strobes: got %b expected 100", {rob_ren, rrf_wen, free_push});
        end
        cyc();
        idle();
        tests++;
        if (instret !== 64'd2) begin fails++; $display("FAIL rd0_instret: got %0d expected 2", instret); end
    endtask

    task automatic test_store();
        set_head(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 6'd0, 6'd0);
        settle();
        tests++;
        if ({rob_ren, store_req, busy} !== 3'b000) begin
            fails++; $display("FAIL store_launch_cycle: got %b expected 000", {rob_ren, store_req, busy});
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            settle();
            tests++;
            if ({store_req, busy, rob_ren, load_req} !== 4'b1100) begin
                fails++; $display("FAIL store_wait%0d: got %b expected 1100", i, {store_req, busy, rob_ren, load_req});
            end
        end
        cyc();
        store_ack = 1'b1;
        settle();
        tests++;
        if ({rob_ren, store_req, rrf_wen, free_push} !== 4'b1100) begin
            fails++; $display("FAIL store_ack_cycle: got %b expected 1100", {rob_ren, store_req, rrf_wen, free_push});
        end
        cyc();
        idle();
        settle();
        tests++;
        if ({store_req, busy} !== 2'b00 || instret !== 64'd3) begin
            fails++; $display("FAIL store_done: got req/busy=%b instret=%0d expected 00 3", {store_req, busy}, instret);
        end
    endtask

    task automatic test_load();
        set_head(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 6'd20, 6'd9);
        cyc();
        settle();
        tests++;
        if ({load_req, busy, rob_ren, rrf_wen} !== 4'b1100) begin
            fails++; $display("FAIL load_wait1: got %b expected 1100", {load_req, busy, rob_ren, rrf_wen});
        end
        cyc();
        load_ack = 1'b1;
        settle();
        tests++;
        if ({rob_ren, rrf_wen, free_push} !== 3'b111 || rrf_rd !== 5'd7 || rrf_pd !== 6'd20 || free_pd !== 6'd9) begin
            fails++; $display("FAIL load_ack_cycle: got %b rd=%0d pd=%0d free=%0d expected 111 7 20 9",
                              {rob_ren, rrf_wen, free_push}, rrf_rd, rrf_pd, free_pd);
        end
        cyc();
        idle();
        settle();
        tests++;
        if (load_req !== 1'b0 || instret !== 64'd4) begin
            fails++; $display("FAIL load_done: got req=%0b instret=%0d expected 0 4", load_req, instret);
        end
    endtask

    task automatic test_boundary();
        // rob_empty overrides head_ready.
        set_head(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 6'd3, 6'd3);
        settle();
        tests++;
        if (rob_ren !== 1'b0) begin fails++; $display("FAIL empty_override: got %0b expected 0", rob_ren); end
        // commit_hold in RUN blocks both retirement and launch.
        set_head(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 6'd0, 6'd0);
        commit_hold = 1'b1;
        cyc();
        settle();
        tests++;
        if ({store_req, load_req, busy, rob_ren} !== 4'b0000) begin
            fails++; $display("FAIL hold_no_launch: got %b expected 0000", {store_req, load_req, busy, rob_ren});
        end
        // Store wins over load; hold raised mid-wait; wrong-type ack ignored.
        commit_hold = 1'b0;
        cyc();
        commit_hold = 1'b1;
        load_ack = 1'b1;
        settle();
        tests++;
        if ({store_req, load_req, rob_ren} !== 3'b100) begin
            fails++; $display("FAIL wrong_ack: got %b expected 100", {store_req, load_req, rob_ren});
        end
        cyc();
        load_ack = 1'b0;
        store_ack = 1'b1;
        settle();
        tests++;
        if (rob_ren !== 1'b1) begin fails++; $display("FAIL hold_in_wait: got %0b expected 1", rob_ren); end
        cyc();
        idle();
        // Spurious load_ack in RUN.
        load_ack = 1'b1;
        settle();
        tests++;
        if ({rob_ren, load_req, busy} !== 3'b000) begin
            fails++; $display("FAIL spurious_ack: got %b expected 000", {rob_ren, load_req, busy});
        end
        cyc();
        idle();
        settle();
        tests++;
        if (busy !== 1'b0 || instret !== 64'd5) begin
            fails++; $display("FAIL spurious_after: got busy=%0b instret=%0d expected 0 5", busy, instret);
        end
    endtask

    task automatic test_reset_mid_wait();
        set_head(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 6'd4, 6'd6);
        cyc();
        rst = 1'b0;
        load_ack = 1'b1;
        settle();
        tests++;
        if (rob_ren !== 1'b0) begin fails++; $display("FAIL rst_wait_rob_ren: got %0b expected 0", rob_ren); end
        cyc();
        settle();
        tests++;
        if ({load_req, busy} !== 2'b00 || instret !== 64'd0) begin
            fails++; $display("FAIL rst_wait_after: got req/busy=%b instret=%0d expected 00 0", {load_req, busy}, instret);
        end
        idle();
        rst = 1'b1;
        cyc();
    endtask

    // Randomized run. The model tracks only "which memory op is outstanding"
    // and an expected retire count; the head is held while something is outstanding.
    task automatic test_random();
        int          pend;     // 0 none, 1 store outstanding, 2 load outstanding
        int          nxt;
        logic [63:0] exp_ir;
        logic        hv, ret, wbm;
        do_reset();
        pend = 0;
        exp_ir = 64'd0;
        for (int n = 0; n < 400; n++) begin
            if (pend == 0) begin
                logic st;
                st = ($urandom_range(0, 3) == 0);
                set_head($urandom_range(0, 5) == 0, $urandom_range(0, 4) != 0, st,
                         $urandom_range(0, 3) == 0, st ? 1'b0 : 1'($urandom_range(0, 1)),
                         5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31)),
                         6'($urandom), 6'($urandom));
            end
            commit_hold = ($urandom_range(0, 5) == 0);
            store_ack   = ($urandom_range(0, 2) == 0);
            load_ack    = ($urandom_range(0, 2) == 0);
            hv  = !rob_empty && head_ready;
            ret = 1'b0;
            nxt = pend;
            if (pend == 1) begin
                if (store_ack) begin ret = 1'b1; nxt = 0; end
            end else if (pend == 2) begin
                if (load_ack) begin ret = 1'b1; nxt = 0; end
            end else if (hv && !commit_hold) begin
                if (head_store)     nxt = 1;
                else if (head_load) nxt = 2;
                else                ret = 1'b1;
            end
            wbm = ret && head_regwrite && head_rd != 5'd0;
            settle();
            tests++;
            if (rob_ren !== ret) begin fails++; $display("FAIL rnd_rob_ren[%0d]: got %0b expected %0b", n, rob_ren, ret); end
            tests++;
            if (rrf_wen !== wbm || free_push !== wbm) begin
                fails++; $display("FAIL rnd_wb[%0d]: got wen=%0b push=%0b expected %0b", n, rrf_wen, free_push, wbm);
            end
            if (wbm) begin
                tests++;
                if (rrf_rd !== head_rd || rrf_pd !== head_pd || free_pd !== head_old_pd) begin
                    fails++; $display("FAIL rnd_fields[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d",
                                      n, rrf_rd, rrf_pd, free_pd, head_rd, head_pd, head_old_pd);
                end
            end
            tests++;
            if (store_req !== (pend == 1) || load_req !== (pend == 2) || busy !== (pend != 0)) begin
                fails++; $display("FAIL rnd_req[%0d]: got st=%0b ld=%0b busy=%0b expected pend=%0d",
                                  n, store_req, load_req, busy, pend);
            end
            tests++;
            if (instret !== exp_ir) begin fails++; $display("FAIL rnd_instret[%0d]: got %0d expected %0d", n, instret, exp_ir); end
            cyc();
            if (ret) exp_ir = exp_ir + 64'd1;
            pend = nxt;
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        cyc();
        test_reset();
        test_alu();
        test_rd0();
        test_store();
        test_load();
        test_boundary();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/commit_ctrl.md
Name: commit_ctrl

Overview:
- Retirement sequencer at the reorder-buffer head. Each cycle it inspects the head entry's status.
- Non-memory ops retire in a single cycle: the architectural register file (RRF) is updated and the stale physical register is freed.
- Loads and stores at the head are launched to the load/store unit through a req/ack handshake. They retire only on ack.
- Drives the ROB dequeue strobe and a retired-instruction counter.

Parameters:
- ARCH_REG_WIDTH, 5, architectural register index width
- PHYS_REG_WIDTH, 6, physical register index width
- INSTRET_WIDTH, 64, retired-instruction counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (asserted when 0)
- rob_empty  in  1  ROB has no valid entries
- head_ready  in  1  head entry has written back
- head_store  in  1  head entry is a store
- head_load  in  1  head entry is a load
- head_regwrite  in  1  head entry writes a destination register
- head_rd  in  ARCH_REG_WIDTH  head architectural destination
- head_pd  in  PHYS_REG_WIDTH  head new physical destination
- head_old_pd  in  PHYS_REG_WIDTH  physical register previously mapped to head_rd
- commit_hold  in  1  blocks new retirements and memory launches (debug/drain)
- store_req  out  1  request to commit head store to memory
- store_ack  in  1  store performed
- load_req  out  1  request to perform head load
- load_ack  in  1  load data written back
- rob_ren  out  1  dequeue head this cycle (single-cycle pulse)
- rrf_wen  out  1  RRF write enable
- rrf_rd  out  ARCH_REG_WIDTH  RRF write index
- rrf_pd  out  PHYS_REG_WIDTH  RRF write data
- free_push  out  1  return head_old_pd to free list
- free_pd  out  PHYS_REG_WIDTH  freed physical register
- instret  out  INSTRET_WIDTH  count of retired instructions
- busy  out  1  controller is in a memory wait state

Behaviour:
- States are RUN, ST_WAIT and LD_WAIT. On reset: state=RUN, instret=0, all outputs 0.
- Head qualifier: hv = ~rob_empty & head_ready. rob_empty overrides head_ready.
- RUN with hv & ~commit_hold:
  - if head_store: next state ST_WAIT; no rob_ren this cycle. head_store has priority if head_store and head_load are both set.
  - else if head_load: next state LD_WAIT; no rob_ren.
  - else: retire combinationally this cycle.
- RUN with ~hv or commit_hold: no action; stay in RUN.
- Retire action (combinational, same cycle):
  - rob_ren=1 and instret increments by 1 at the clock edge.
  - If head_regwrite & head_rd!=0: rrf_wen=1, rrf_rd=head_rd, rrf_pd=head_pd, free_push=1, free_pd=head_old_pd. Otherwise all four are 0.
- ST_WAIT:
  - store_req=1 (registered state decode), held until store_ack.
  - The cycle store_ack=1: retire action (store has no regwrite), next state RUN.
  - Minimum store retire latency is 2 cycles from hv.
- LD_WAIT:
  - load_req=1, held until load_ack.
  - On load_ack: retire action including RRF/free-list update, next state RUN.
- Head is not re-evaluated in wait states. The head is stable by construction because it is non-speculative and not dequeued.
- commit_hold does not abort a wait state in progress.
- At most one retirement per cycle.
- Acks received in RUN, or an ack for the wrong type, are ignored.
- busy = (state != RUN).
- instret wraps modulo 2^INSTRET_WIDTH.
- Reset (rst=0) mid-wait: store_req/load_req drop on the next edge; state=RUN; no rob_ren is issued.
- All outputs except store_req/load_req/busy/instret are combinational from state and inputs. There are no combinational paths from req outputs to ack inputs.

Test Plan:
- ALU op with rd=5, pd=12, old_pd=3, hv=1 → same cycle: rob_ren=1, rrf_wen=1 (rd=5, pd=12), free_push=1 (pd=3); instret 0→1.
- rd=0 with regwrite=1 → rob_ren=1, rrf_wen=0, free_push=0.
- Store at head, store_ack held low 3 cycles → store_req=1 from cycle+1 until ack; rob_ren=1 only in the ack cycle; busy=1 throughout the wait.
- Load rd=7, pd=20, old_pd=9, ack on the 2nd wait cycle → rob_ren, rrf_wen and free_push all fire in the ack cycle.
- Boundary: rob_empty=1 with head_ready=1 → no rob_ren. commit_hold=1 in RUN → no launch. commit_hold asserted during ST_WAIT → ack still retires. Spurious load_ack in RUN → ignored.
- Reset: rst=0 during LD_WAIT → next cycle load_req=0, busy=0, instret=0.
